dd_bus_sequencer: RTL and testbench

Cycle sequencer and arbiter for the shared IDE/clockport data bus (DD[15:0]) in the A500 IDE/RAM CPLD. It accepts decoded access requests from the IDE range and the clockport range, grants the bus to one requester at a time, and generates timed active-low strobes (_DIOR/_DIOW or _IORD/_IOWR). It also latches read data, drives the bus output enables and raises a DTACK request to the top level. The block replaces the purely combinational clockport strobes with programmable setup/strobe/hold timing.

---
 rtl/dd_bus_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_dd_bus_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dd_bus_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dd_bus_sequencer
// Purpose  : Arbiter and strobe sequencer for the shared IDE/clockport DD bus.
//            Optional macro DD_BUS_ROUND_ROBIN_EN enables round-robin arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module dd_bus_sequencer #(
    parameter int IDE_SETUP  = 1,
    parameter int IDE_STROBE = 3,
    parameter int CP_SETUP   = 1,
    parameter int CP_STROBE  = 4,
    parameter int HOLD       = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ide_req,
    input  logic        cp_req,
    input  logic        rw,
    input  logic [15:0] dd_in,
    output logic [15:0] rdata,
    output logic        gnt_ide,
    output logic        gnt_cp,
    output logic        _DIOR,
    output logic        _DIOW,
    output logic        _IORD,
    output logic        _IOWR,
    output logic        dd_oe,
    output logic        d_oe,
    output logic        dtack,
    output logic        busy
);

    // Counter reload values; a zero parameter is treated as one cycle.
    localparam logic [3:0] IDE_SETUP_CNT  = (IDE_SETUP  < 1) ? 4'd0 : 4'(IDE_SETUP  - 1);
    localparam logic [3:0] IDE_STROBE_CNT = (IDE_STROBE < 1) ? 4'd0 : 4'(IDE_STROBE - 1);
    localparam logic [3:0] CP_SETUP_CNT   = (CP_SETUP   < 1) ? 4'd0 : 4'(CP_SETUP   - 1);
    localparam logic [3:0] CP_STROBE_CNT  = (CP_STROBE  < 1) ? 4'd0 : 4'(CP_STROBE  - 1);
    localparam logic [3:0] HOLD_CNT       = (HOLD       < 1) ? 4'd0 : 4'(HOLD       - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_ACK    = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        sel_cp_q, sel_cp_d;
    logic        rd_q, rd_d;
    logic        dropped_q, dropped_d;
    logic [15:0] rdata_q, rdata_d;
    logic        gnt_ide_q, gnt_ide_d, gnt_cp_q, gnt_cp_d;
    logic        dior_q, dior_d, diow_q, diow_d, iord_q, iord_d, iowr_q, iowr_d;
    logic        dd_oe_q, dd_oe_d, d_oe_q, d_oe_d, dtack_q, dtack_d, busy_q, busy_d;
    logic        gnt_req;
    logic        cp_wins;

`ifdef DD_BUS_ROUND_ROBIN_EN
    logic        last_cp_q, last_cp_d;
    // On a tie the requester that did not win last time gets the bus.
    assign cp_wins = cp_req & (~ide_req | ~last_cp_q);
`else
    assign cp_wins = cp_req & ~ide_req;
`endif

    assign gnt_req = sel_cp_q ? cp_req : ide_req;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            sel_cp_q  <= 1'b0;
            rd_q      <= 1'b0;
            dropped_q <= 1'b0;
            rdata_q   <= 16'h0000;
            gnt_ide_q <= 1'b0;
            gnt_cp_q  <= 1'b0;
            dior_q    <= 1'b1;
            diow_q    <= 1'b1;
            iord_q    <= 1'b1;
            iowr_q    <= 1'b1;
            dd_oe_q   <= 1'b0;
            d_oe_q    <= 1'b0;
            dtack_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifdef DD_BUS_ROUND_ROBIN_EN
            last_cp_q <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_cp_q  <= sel_cp_d;
            rd_q      <= rd_d;
            dropped_q <= dropped_d;
            rdata_q   <= rdata_d;
            gnt_ide_q <= gnt_ide_d;
            gnt_cp_q  <= gnt_cp_d;
            dior_q    <= dior_d;
            diow_q    <= diow_d;
            iord_q    <= iord_d;
            iowr_q    <= iowr_d;
            dd_oe_q   <= dd_oe_d;
            d_oe_q    <= d_oe_d;
            dtack_q   <= dtack_d;
            busy_q    <= busy_d;
`ifdef DD_BUS_ROUND_ROBIN_EN
            last_cp_q <= last_cp_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_cp_d  = sel_cp_q;
        rd_d      = rd_q;
        dropped_d = dropped_q;
        rdata_d   = rdata_q;
`ifdef DD_BUS_ROUND_ROBIN_EN
        last_cp_d = last_cp_q;
`endif
        // An early request drop is remembered so ACK lasts a single cycle.
        if ((state_q == ST_SETUP || state_q == ST_STROBE || state_q == ST_HOLD) && !gnt_req)
            dropped_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (ide_req || cp_req) begin
                    state_d   = ST_SETUP;
                    sel_cp_d  = cp_wins;
                    rd_d      = rw;
                    dropped_d = 1'b0;
                    cnt_d     = cp_wins ? CP_SETUP_CNT : IDE_SETUP_CNT;
`ifdef DD_BUS_ROUND_ROBIN_EN
                    last_cp_d = cp_wins;
`endif
                end
            end
            ST_SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_STROBE;
                    cnt_d   = sel_cp_q ? CP_STROBE_CNT : IDE_STROBE_CNT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_CNT;
                    if (rd_q)
                        rdata_d = dd_in;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0)
                    state_d = ST_ACK;
                else
                    cnt_d = cnt_q - 4'd1;
            end
            ST_ACK: begin
                if (!gnt_req || dropped_q)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_comb begin
        busy_d    = (state_d != ST_IDLE);
        gnt_ide_d = busy_d & ~sel_cp_d;
        gnt_cp_d  = busy_d &  sel_cp_d;
        dior_d    = ~((state_d == ST_STROBE) & ~sel_cp_d &  rd_d);
        diow_d    = ~((state_d == ST_STROBE) & ~sel_cp_d & ~rd_d);
        iord_d    = ~((state_d == ST_STROBE) &  sel_cp_d &  rd_d);
        iowr_d    = ~((state_d == ST_STROBE) &  sel_cp_d & ~rd_d);
        dd_oe_d   = ~rd_d & (state_d == ST_SETUP || state_d == ST_STROBE || state_d == ST_HOLD);
        dtack_d   = (state_d == ST_ACK);
        d_oe_d    = rd_d & dtack_d;
    end

    assign rdata   = rdata_q;
    assign gnt_ide = gnt_ide_q;
    assign gnt_cp  = gnt_cp_q;
    assign _DIOR   = dior_q;
    assign _DIOW   = diow_q;
    assign _IORD   = iord_q;
    assign _IOWR   = iowr_q;
    assign dd_oe   = dd_oe_q;
    assign d_oe    = d_oe_q;
    assign dtack   = dtack_q;
    assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dd_bus_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dd_bus_sequencer
// Purpose  : Directed and randomized check of dd_bus_sequencer timing against
//            a per-transaction schedule model. Honours DD_BUS_ROUND_ROBIN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dd_bus_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ide_req [2];
    logic        cp_req  [2];
    logic        rw      [2];
    logic [15:0] dd_in   [2];
    logic [15:0] rdata   [2];
    logic        gnt_ide [2];
    logic        gnt_cp  [2];
    logic        dior_n  [2];
    logic        diow_n  [2];
    logic        iord_n  [2];
    logic        iowr_n  [2];
    logic        dd_oe   [2];
    logic        d_oe    [2];
    logic        dtack   [2];
    logic        busy    [2];

    int          errors = 0;
    int          checks = 0;
    logic [15:0] m_rdata   [2];
    bit          m_last_cp [2];

    always #5 CLK = ~CLK;

    dd_bus_sequencer u_dut0 (
        .CLK(CLK), .RESET(RESET), .ide_req(ide_req[0]), .cp_req(cp_req[0]), .rw(rw[0]),
        .dd_in(dd_in[0]), .rdata(rdata[0]), .gnt_ide(gnt_ide[0]), .gnt_cp(gnt_cp[0]),
        ._DIOR(dior_n[0]), ._DIOW(diow_n[0]), ._IORD(iord_n[0]), ._IOWR(iowr_n[0]),
        .dd_oe(dd_oe[0]), .d_oe(d_oe[0]), .dtack(dtack[0]), .busy(busy[0])
    );

    dd_bus_sequencer #(.IDE_STROBE(0)) u_dut1 (
        .CLK(CLK), .RESET(RESET), .ide_req(ide_req[1]), .cp_req(cp_req[1]), .rw(rw[1]),
        .dd_in(dd_in[1]), .rdata(rdata[1]), .gnt_ide(gnt_ide[1]), .gnt_cp(gnt_cp[1]),
        ._DIOR(dior_n[1]), ._DIOW(diow_n[1]), ._IORD(iord_n[1]), ._IOWR(iowr_n[1]),
        .dd_oe(dd_oe[1]), .d_oe(d_oe[1]), .dtack(dtack[1]), .busy(busy[1])
    );

    // {gnt_ide, gnt_cp, _DIOR, _DIOW, _IORD, _IOWR, dd_oe, d_oe, dtack, busy, rdata}
    function automatic logic [25:0] observed(input int d);
        return {gnt_ide[d], gnt_cp[d], dior_n[d], diow_n[d], iord_n[d], iowr_n[d],
                dd_oe[d], d_oe[d], dtack[d], busy[d], rdata[d]};
    endfunction

    task automatic check(input int d, input logic [25:0] exp, input string tag, input int k);
        logic [25:0] got;
        got = observed(d);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s dut%0d edge %0d observed=%h expected=%h", tag, d, k, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_rdata[i]   = 16'h0000;
            m_last_cp[i] = 1'b1;
        end
    endtask

    // One bus transaction. Edge 0 is the grant edge. The request stays high through
    // edge D (early drop when drop_d >= 0, else until hold_extra cycles past dtack).
    task automatic txn(input int d, input bit ide, input bit cp, input bit r,
                       input logic [15:0] data, input int hold_extra,
                       input int drop_d, input int rst_k, input string tag);
        bit win_cp, st, dt, act;
        int s, w, h, a, dl, rl;
        logic [25:0] exp;
        @(negedge CLK);
        ide_req[d] = ide;
        cp_req[d]  = cp;
        rw[d]      = r;
        dd_in[d]   = data;
`ifdef DD_BUS_ROUND_ROBIN_EN
        win_cp = cp && (!ide || !m_last_cp[d]);
`else
        win_cp = cp && !ide;
`endif
        m_last_cp[d] = win_cp;
        s  = 1;
        w  = win_cp ? 4 : ((d == 1) ? 1 : 3);
        h  = 1;
        a  = s + w + h;
        dl = (drop_d >= 0) ? drop_d : a + hold_extra;
        rl = ((dl > a) ? dl : a) + 1;
        for (int k = 0; k <= rl; k++) begin
            @(posedge CLK);
            #1;
            if (k == 0)
                rw[d] = 1'($urandom);
            if (k == s + w && r)
                m_rdata[d] = data;
            act = (k < rl);
            st  = (k >= s) && (k < s + w);
            dt  = (k >= a) && (k < rl);
            exp = {act && !win_cp, act && win_cp,
                   !(st && !win_cp && r), !(st && !win_cp && !r),
                   !(st && win_cp && r),  !(st && win_cp && !r),
                   !r && (k < a), r && dt, dt, act, m_rdata[d]};
            check(d, exp, tag, k);
            if (k == rst_k) begin
                #1 RESET = 1'b1;
                model_reset();
                #1 check(d, {2'b00, 4'b1111, 4'b0000, 16'h0000}, {tag, "_async"}, k);
                ide_req[d] = 1'b0;
                cp_req[d]  = 1'b0;
                @(negedge CLK);
                RESET = 1'b0;
                return;
            end
            if (k == dl) begin
                @(negedge CLK);
                ide_req[d] = 1'b0;
                cp_req[d]  = 1'b0;
            end
        end
    endtask

    initial begin
        int d, dl;
        bit ide, cp;
        RESET = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ide_req[i] = 1'b0;
            cp_req[i]  = 1'b0;
            rw[i]      = 1'b0;
            dd_in[i]   = 16'h0000;
        end
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check(0, {2'b00, 4'b1111, 4'b0000, 16'h0000}, "reset", 0);
        check(1, {2'b00, 4'b1111, 4'b0000, 16'h0000}, "reset", 0);
        @(negedge CLK);
        RESET = 1'b0;

        txn(0, 1, 0, 1, 16'hA55A, 0, -1, -1, "ide_read");
        txn(0, 0, 1, 0, 16'h1234, 0, -1, -1, "cp_write");
        txn(0, 1, 1, 1, 16'h0F0F, 1, -1, -1, "tie_1");
        txn(0, 1, 1, 0, 16'hF0F0, 0, -1, -1, "tie_2");
        txn(0, 0, 1, 1, 16'hBEEF, 0,  1, -1, "cp_early_drop");
        txn(0, 1, 0, 1, 16'hC0DE, 0, -1,  2, "reset_mid_strobe");
        txn(0, 1, 0, 1, 16'h5AA5, 0, -1, -1, "after_reset");
        txn(1, 1, 0, 1, 16'h7E57, 0, -1, -1, "strobe0_read");
        txn(1, 1, 0, 0, 16'h0000, 2, -1, -1, "strobe0_write");

        for (int i = 0; i < 40; i++) begin
            d   = i % 2;
            ide = 1'($urandom);
            cp  = 1'($urandom);
            if (!ide && !cp)
                ide = 1'b1;
            dl  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
            txn(d, ide, cp, 1'($urandom), 16'($urandom), int'($urandom_range(0, 3)),
                dl, -1, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
